// File: rtl/axis_pkg_counter_gen_if.sv
// AXI4-Stream master-to-consumer bundle used by the package-count generator.
interface axis_pkg_counter_gen_if #(
  parameter int unsigned TDATA_W = 3
) ();
  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic               tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_pkg_counter_gen.sv
// Package-count generator: a tick counter frames packages, each package count is
// queued in a FWFT FIFO and serialised LSB-beat-first onto an AXI-Stream master.
module axis_pkg_counter_gen #(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned TDATA_W     = 3,
  parameter int unsigned TICK_PERIOD = 11,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DROP_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [CNT_W-1:0]              i_cnt_limit,
  axis_pkg_counter_gen_if.master        m_axis,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [DROP_W-1:0]             o_drop_cnt
);

  localparam int unsigned BEATS  = (CNT_W + TDATA_W - 1) / TDATA_W;
  localparam int unsigned SHR_W  = BEATS * TDATA_W;
  localparam int unsigned TICK_W = $clog2(TICK_PERIOD);
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  logic [TICK_W-1:0] r_tick;
  logic [CNT_W-1:0]  r_pkg;
  logic [DROP_W-1:0] r_drop;
  logic [CNT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [LVL_W-1:0]  r_level;
  state_t            r_state;
  logic [SHR_W-1:0]  r_shreg;
  logic [BEAT_W-1:0] r_beat;

  logic              w_tick_end;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_wr;
  logic              w_pop;
  logic              w_shift;
  logic              w_last_beat;
  logic [CNT_W-1:0]  w_pkg_nxt;
  logic [CNT_W-1:0]  w_head;
  state_t            w_state_nxt;

  assign w_tick_end  = (r_tick == TICK_LAST);
  assign w_push      = w_tick_end && i_start;
  assign w_pkg_nxt   = (r_pkg >= i_cnt_limit) ? '0 : r_pkg + CNT_W'(1);
  // Fullness is judged on the registered level, so a same-cycle pop never rescues a push.
  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_wr        = w_push && !w_full;
  assign w_head      = r_mem[r_rptr];
  assign w_last_beat = (r_beat == BEAT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
    end else begin
      r_tick <= w_tick_end ? '0 : r_tick + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkg  <= '0;
      r_drop <= '0;
    end else begin
      if (w_push) begin
        r_pkg <= w_pkg_nxt;
      end
      if (w_push && w_full && (r_drop != '1)) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_pkg_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ADDR_W'(1);
      end
      r_level <= r_level + LVL_W'(w_wr) - LVL_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // tvalid is exactly "in SEND", so a handshake in SEND reduces to tready.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (m_axis.tready) begin
          if (!w_last_beat) begin
            w_shift = 1'b1;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_beat  <= '0;
    end else if (w_pop) begin
      r_shreg <= SHR_W'(w_head);
      r_beat  <= '0;
    end else if (w_shift) begin
      r_shreg <= r_shreg >> TDATA_W;
      r_beat  <= r_beat + BEAT_W'(1);
    end
  end

  assign m_axis.tvalid = (r_state == S_SEND);
  assign m_axis.tdata  = r_shreg[TDATA_W-1:0];
  assign m_axis.tlast  = (r_state == S_SEND) && w_last_beat;

  assign o_fifo_level  = r_level;
  assign o_drop_cnt    = r_drop;

endmodule

// File: tb/tb_axis_pkg_counter_gen.sv
// Bench for axis_pkg_counter_gen: spec-level package model feeding a word
// scoreboard, a reset/latency vector table and hand-written corner sequences.
module tb_axis_pkg_counter_gen;

  localparam int TP    = 11;
  localparam int BEATS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] cnt_limit;
  logic [3:0] fifo_level;
  logic [7:0] drop_cnt;

  logic       rst_v;
  logic       start_v;
  logic [7:0] limit_v;
  logic [3:0] fifo_level_v;
  logic [7:0] drop_v;

  always #5 clk = ~clk;

  axis_pkg_counter_gen_if #(.TDATA_W(3)) ax ();
  axis_pkg_counter_gen_if #(.TDATA_W(3)) ax_v ();

  axis_pkg_counter_gen #(
    .CNT_W(6), .TDATA_W(3), .TICK_PERIOD(11), .FIFO_DEPTH(8), .DROP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_cnt_limit(cnt_limit),
    .m_axis(ax), .o_fifo_level(fifo_level), .o_drop_cnt(drop_cnt)
  );

  axis_pkg_counter_gen #(
    .CNT_W(8), .TDATA_W(3), .TICK_PERIOD(4), .FIFO_DEPTH(8), .DROP_W(8)
  ) dut_v (
    .clk(clk), .rst(rst_v), .i_start(start_v), .i_cnt_limit(limit_v),
    .m_axis(ax_v), .o_fifo_level(fifo_level_v), .o_drop_cnt(drop_v)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Package model and output monitor, sampled mid-cycle.
  int   mtick, mpkg, push_cnt;
  int   acc_limit = 1000000;
  int   exp_q[$];
  int   got_log[$];
  int   mbeat, mword, words_done, last_word;
  logic prev_stall;
  logic [2:0] prev_data;
  logic prev_last;

  int   vbeat, vwords;
  logic [2:0] vdata [3];
  logic vlast [3];
  logic [2:0] cap_d [3];
  logic cap_l [3];

  always @(negedge clk) begin
    if (rst) begin
      mtick = 0; mpkg = 0; push_cnt = 0;
      exp_q.delete(); got_log.delete();
      mbeat = 0; mword = 0; words_done = 0; prev_stall = 1'b0;
    end else begin
      if (mtick == TP - 1 && start) begin
        mpkg = (mpkg >= int'(cnt_limit)) ? 0 : mpkg + 1;
        push_cnt++;
        if (push_cnt <= acc_limit) exp_q.push_back(mpkg);
      end
      mtick = (mtick == TP - 1) ? 0 : mtick + 1;

      if (prev_stall) begin
        chk("hold_tvalid", int'(ax.tvalid), 1);
        chk("hold_tdata", int'(ax.tdata), int'(prev_data));
        chk("hold_tlast", int'(ax.tlast), int'(prev_last));
      end

      if (ax.tvalid && ax.tready) begin
        chk("tlast_pos", int'(ax.tlast), int'(mbeat == BEATS - 1));
        mword = mword | (int'(ax.tdata) << (3 * mbeat));
        if (ax.tlast || mbeat == BEATS - 1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL word_extra: got %0d required none", mword);
          end else begin
            chk("word", mword, exp_q.pop_front());
          end
          words_done++;
          last_word = mword;
          got_log.push_back(mword);
          mbeat = 0;
          mword = 0;
        end else begin
          mbeat++;
        end
      end
      prev_stall = ax.tvalid && !ax.tready;
      prev_data  = ax.tdata;
      prev_last  = ax.tlast;
    end

    if (rst_v) begin
      vbeat = 0; vwords = 0;
    end else if (ax_v.tvalid && ax_v.tready) begin
      vdata[vbeat] = ax_v.tdata;
      vlast[vbeat] = ax_v.tlast;
      if (ax_v.tlast || vbeat == 2) begin
        vwords++;
        if (vwords == 165) begin
          cap_d = vdata;
          cap_l = vlast;
        end
        vbeat = 0;
      end else begin
        vbeat++;
      end
    end
  end

  typedef struct {
    int         cyc;
    logic       tv;
    logic [2:0] td;
    logic       tl;
    logic [3:0] lvl;
  } vec_t;

  vec_t vec [7];
  int   wrap_seq [9];

  initial begin
    int  t;
    bit  found;

    vec[0] = '{0,  1'b0, 3'd0, 1'b0, 4'd0};
    vec[1] = '{5,  1'b0, 3'd0, 1'b0, 4'd0};
    vec[2] = '{10, 1'b0, 3'd0, 1'b0, 4'd0};
    vec[3] = '{11, 1'b0, 3'd0, 1'b0, 4'd1};
    vec[4] = '{12, 1'b1, 3'd1, 1'b0, 4'd0};
    vec[5] = '{13, 1'b1, 3'd0, 1'b1, 4'd0};
    vec[6] = '{14, 1'b0, 3'd0, 1'b0, 4'd0};
    wrap_seq = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

    rst = 1'b1; rst_v = 1'b1;
    start = 1'b1; cnt_limit = 6'd3; ax.tready = 1'b1;
    start_v = 1'b1; limit_v = 8'hFF; ax_v.tready = 1'b1;

    // Reset held with start/tready high.
    step(1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tvalid", int'(ax.tvalid), 0);
      chk("rst_tdata", int'(ax.tdata), 0);
      chk("rst_tlast", int'(ax.tlast), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      step(1);
    end
    rst = 1'b0; rst_v = 1'b0;

    // First-word latency vectors, cycle 0 = first cycle with rst low.
    t = 0;
    for (int c = 0; c < 15; c++) begin
      if (t < 7 && vec[t].cyc == c) begin
        chk($sformatf("c%0d_tvalid", c), int'(ax.tvalid), int'(vec[t].tv));
        chk($sformatf("c%0d_tlast", c), int'(ax.tlast), int'(vec[t].tl));
        chk($sformatf("c%0d_level", c), int'(fifo_level), int'(vec[t].lvl));
        if (vec[t].tv || c == 0)
          chk($sformatf("c%0d_tdata", c), int'(ax.tdata), int'(vec[t].td));
        t++;
      end
      step(1);
    end

    // Wrap at cnt_limit=3.
    step(100);
    chk("wrap_count", int'(got_log.size() >= 9), 1);
    for (int i = 0; i < 9; i++)
      if (i < got_log.size()) chk($sformatf("wrap_w%0d", i), got_log[i], wrap_seq[i]);
    chk("wrap_drop", int'(drop_cnt), 0);

    // Long stall: FIFO fills, overflow counted, then drain in order.
    rst = 1'b1; ax.tready = 1'b0; cnt_limit = 6'd63; acc_limit = 9;
    step(2);
    rst = 1'b0;
    step(200);
    chk("stall_tvalid", int'(ax.tvalid), 1);
    chk("stall_tdata", int'(ax.tdata), 1);
    chk("stall_tlast", int'(ax.tlast), 0);
    chk("stall_level", int'(fifo_level), 8);
    chk("stall_drop", int'(drop_cnt), push_cnt - 9);
    start = 1'b0; ax.tready = 1'b1;
    step(30);
    chk("drain_words", words_done, 9);
    for (int i = 0; i < 9; i++)
      if (i < got_log.size()) chk($sformatf("drain_w%0d", i), got_log[i], i + 1);
    chk("drain_level", int'(fifo_level), 0);
    chk("drain_tvalid", int'(ax.tvalid), 0);
    chk("drain_drop", int'(drop_cnt), push_cnt - 9);
    chk("drain_sb_empty", exp_q.size(), 0);
    acc_limit = 1000000;

    // Reset mid-word with three words queued.
    start = 1'b1; ax.tready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (fifo_level == 4'd3) found = 1'b1;
      else step(1);
    end
    chk("mid_level3_reached", int'(found), 1);
    chk("mid_beat0_tvalid", int'(ax.tvalid), 1);
    chk("mid_beat0_tlast", int'(ax.tlast), 0);
    ax.tready = 1'b1;
    step(1);
    ax.tready = 1'b0;
    chk("mid_beat1_tlast", int'(ax.tlast), 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_tvalid", int'(ax.tvalid), 0);
    chk("mid_rst_tlast", int'(ax.tlast), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    rst = 1'b0; ax.tready = 1'b1;
    step(15);
    chk("restart_words", words_done, 1);
    chk("restart_word1", last_word, 1);

    // tready toggling with start gated 5 packages on / 3 off.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      start = 1'b1;
      for (int i = 0; i < 55; i++) begin
        ax.tready = ~ax.tready;
        step(1);
      end
      start = 1'b0;
      for (int i = 0; i < 33; i++) begin
        ax.tready = ~ax.tready;
        step(1);
      end
    end
    ax.tready = 1'b1;
    step(20);
    chk("toggle_words", words_done, 15);
    chk("toggle_last", last_word, 15);
    chk("toggle_drop", int'(drop_cnt), 0);
    chk("toggle_level", int'(fifo_level), 0);
    chk("toggle_sb_empty", exp_q.size(), 0);

    // Wide-word variant: word 0xA5 split into three beats.
    for (int i = 0; i < 2000 && vwords < 165; i++) step(1);
    chk("var_reached", int'(vwords >= 165), 1);
    chk("var_beat0", int'(cap_d[0]), 5);
    chk("var_beat1", int'(cap_d[1]), 4);
    chk("var_beat2", int'(cap_d[2]), 2);
    chk("var_last0", int'(cap_l[0]), 0);
    chk("var_last1", int'(cap_l[1]), 0);
    chk("var_last2", int'(cap_l[2]), 1);
    chk("var_drop", int'(drop_v), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
